// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART receiver
// Purpose: FSM state encodings, parity mode constants and a parity helper.
// Ports: none (package).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START_BIT  = 3'd1;
    localparam logic [2:0] ST_DATA_BITS  = 3'd2;
    localparam logic [2:0] ST_PARITY_BIT = 3'd3;
    localparam logic [2:0] ST_STOP_BIT   = 3'd4;
    localparam logic [2:0] ST_CLEANUP    = 3'd5;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd6;

    // data_xor is the XOR of all received data bits; result is 1 on a mismatch.
    function automatic logic parity_bad(input logic data_xor, input logic pbit, input int mode);
        logic sum;
        sum = data_xor ^ pbit;
        return (mode == PARITY_ODD) ? ~sum : sum;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit clock counter with half-bit and full-bit ticks
// Purpose: counts clocks within one UART bit period.
// Ports:
//   clock       - rising-edge clock
//   reset_n     - asynchronous active-low reset
//   clear_i     - restart the count at 0 on the next edge
//   half_tick_o - count is at the middle of a bit, (CLOCKS_PER_BIT-1)/2
//   full_tick_o - count is at the last clock of a bit, CLOCKS_PER_BIT-1
module uart_bit_timer #(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    output logic half_tick_o,
    output logic full_tick_o
);

    // Largest value held is CLOCKS_PER_BIT-1, which always fits in $clog2 bits.
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_COUNT = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign half_tick_o = (count_q == HALF_COUNT);
    assign full_tick_o = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || full_tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART frame receiver with parity, framing and break detection
// Purpose: deserialises start/data/parity/stop frames from an asynchronous line.
// Ports:
//   clock          - rising-edge clock
//   reset_n        - asynchronous active-low reset
//   incoming_bit   - serial line, idle high
//   has_data       - one-clock pulse per completed frame
//   data_received  - data of the last completed frame
//   parity_error   - parity mismatch in the last completed frame
//   framing_error  - a stop bit was sampled low in the last completed frame
//   break_detected - last completed frame was a line break
//   debug_state    - FSM state, delayed one clock
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 incoming_bit,
    output logic                 has_data,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 break_detected,
    output logic [2:0]           debug_state
);

    logic sync1_q;
    logic sync2_q;
    logic line;

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_bit_q, parity_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic                 stop_all_low_q, stop_all_low_d;
    logic                 has_data_q, has_data_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic [2:0]           dbg_q;

    logic timer_clear;
    logic half_tick;
    logic full_tick;
    logic frame_err;
    logic all_low;
    logic is_break;

    assign line = sync2_q;

    // The timer free-runs only while a frame is being timed; the restart at the
    // start-bit midpoint makes every later full tick land mid-bit.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_CLEANUP) ||
                         (state_q == ST_BREAK_WAIT) ||
                         ((state_q == ST_START_BIT) && half_tick);

    uart_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear_i     (timer_clear),
        .half_tick_o (half_tick),
        .full_tick_o (full_tick)
    );

    // Stop-bit accumulators including the current sample.
    assign frame_err = stop_err_q | ~line;
    assign all_low   = stop_all_low_q & ~line;
    assign is_break  = (shift_q == '0) &&
                       ((PARITY_MODE == PARITY_NONE) || !parity_bit_q) && all_low;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_idx_d      = bit_idx_q;
        stop_idx_d     = stop_idx_q;
        parity_bit_d   = parity_bit_q;
        stop_err_d     = stop_err_q;
        stop_all_low_d = stop_all_low_q;
        has_data_d     = 1'b0;
        data_d         = data_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        brk_d          = brk_q;

        case (state_q)
            ST_IDLE: begin
                bit_idx_d      = '0;
                stop_idx_d     = 1'b0;
                parity_bit_d   = 1'b0;
                stop_err_d     = 1'b0;
                stop_all_low_d = 1'b1;
                if (!line) begin
                    state_d = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (half_tick) begin
                    state_d = line ? ST_IDLE : ST_DATA_BITS;
                end
            end
            ST_DATA_BITS: begin
                if (full_tick) begin
                    // LSB arrives first and ends up at index 0 after the last shift.
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY_BIT : ST_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY_BIT: begin
                if (full_tick) begin
                    parity_bit_d = line;
                    state_d      = ST_STOP_BIT;
                end
            end
            ST_STOP_BIT: begin
                if (full_tick) begin
                    stop_err_d     = frame_err;
                    stop_all_low_d = all_low;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d    = ST_CLEANUP;
                        has_data_d = 1'b1;
                        data_d     = shift_q;
                        brk_d      = is_break;
                        ferr_d     = frame_err | is_break;
                        if (is_break || (PARITY_MODE == PARITY_NONE)) begin
                            perr_d = 1'b0;
                        end else begin
                            perr_d = parity_bad(^shift_q, parity_bit_q, PARITY_MODE);
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            ST_CLEANUP: begin
                state_d = brk_q ? ST_BREAK_WAIT : ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_idx_q      <= '0;
            stop_idx_q     <= 1'b0;
            parity_bit_q   <= 1'b0;
            stop_err_q     <= 1'b0;
            stop_all_low_q <= 1'b1;
            has_data_q     <= 1'b0;
            data_q         <= '0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            brk_q          <= 1'b0;
            dbg_q          <= ST_IDLE;
        end else begin
            sync1_q        <= incoming_bit;
            sync2_q        <= sync1_q;
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_idx_q      <= bit_idx_d;
            stop_idx_q     <= stop_idx_d;
            parity_bit_q   <= parity_bit_d;
            stop_err_q     <= stop_err_d;
            stop_all_low_q <= stop_all_low_d;
            has_data_q     <= has_data_d;
            data_q         <= data_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            brk_q          <= brk_d;
            dbg_q          <= state_q;
        end
    end

    assign has_data       = has_data_q;
    assign data_received  = data_q;
    assign parity_error   = perr_q;
    assign framing_error  = ferr_q;
    assign break_detected = brk_q;
    assign debug_state    = dbg_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for three receiver configurations
module tb_uart_receiver;

    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] hd, pe, fe, bk;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [8:0] dr [3];
    logic [2:0] ds [3];

    int checks = 0;
    int errors = 0;

    exp_t exp_q [3][$];
    exp_t last  [3];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign dr[0] = {1'b0, d0};
    assign dr[1] = {1'b0, d1};
    assign dr[2] = {2'b00, d2};

    uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clock(clk), .reset_n(rst_n), .incoming_bit(rx[0]), .has_data(hd[0]),
        .data_received(d0), .parity_error(pe[0]), .framing_error(fe[0]),
        .break_detected(bk[0]), .debug_state(ds[0]));

    uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .clock(clk), .reset_n(rst_n), .incoming_bit(rx[1]), .has_data(hd[1]),
        .data_received(d1), .parity_error(pe[1]), .framing_error(fe[1]),
        .break_detected(bk[1]), .debug_state(ds[1]));

    uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
        .clock(clk), .reset_n(rst_n), .incoming_bit(rx[2]), .has_data(hd[2]),
        .data_received(d2), .parity_error(pe[2]), .framing_error(fe[2]),
        .break_detected(bk[2]), .debug_state(ds[2]));

    function automatic int cfg_bits(input int k);
        return (k == 2) ? 7 : 8;
    endfunction

    function automatic int cfg_pmode(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic int cfg_stops(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Reference: frame outcome from counts of ones and stop-bit values.
    function automatic exp_t model(input int k, input logic [8:0] data, input logic pbit,
                                   input logic [1:0] stops);
        exp_t e;
        int   ones;
        int   pm;
        logic any_low;
        logic all_low;
        pm      = cfg_pmode(k);
        ones    = $countones(data) + int'(pbit);
        any_low = 1'b0;
        all_low = 1'b1;
        for (int s = 0; s < cfg_stops(k); s++) begin
            if (stops[s] == 1'b0) any_low = 1'b1;
            else                  all_low = 1'b0;
        end
        e.data = data;
        e.fe   = any_low;
        e.bk   = 1'b0;
        if (pm == 0)      e.pe = 1'b0;
        else if (pm == 1) e.pe = ((ones % 2) == 0);
        else              e.pe = ((ones % 2) == 1);
        if (data == 9'd0 && (pm == 0 || pbit == 1'b0) && all_low) begin
            e.bk = 1'b1;
            e.fe = 1'b1;
            e.pe = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, k, act, expv);
        end
    endtask

    task automatic check_hold(input int k);
        check("hold_has_data", k, 32'(hd[k]), 32'd0);
        check("hold_data", k, 32'(dr[k]), 32'(last[k].data));
        check("hold_parity", k, 32'(pe[k]), 32'(last[k].pe));
        check("hold_framing", k, 32'(fe[k]), 32'(last[k].fe));
        check("hold_break", k, 32'(bk[k]), 32'(last[k].bk));
    endtask

    task automatic drive_bit(input int k, input logic b);
        rx[k] = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops);
        exp_q[k].push_back(model(k, data, pbit, stops));
        drive_bit(k, 1'b0);
        for (int i = 0; i < cfg_bits(k); i++) drive_bit(k, data[i]);
        if (cfg_pmode(k) != 0) drive_bit(k, pbit);
        for (int s = 0; s < cfg_stops(k); s++) drive_bit(k, stops[s]);
        rx[k] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Monitor: every has_data cycle consumes one expected frame.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (hd[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    check("unexpected_has_data", k, 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[k].pop_front();
                    check("data", k, 32'(dr[k]), 32'(mon_e.data));
                    check("parity_error", k, 32'(pe[k]), 32'(mon_e.pe));
                    check("framing_error", k, 32'(fe[k]), 32'(mon_e.fe));
                    check("break_detected", k, 32'(bk[k]), 32'(mon_e.bk));
                    last[k] = mon_e;
                end
            end
        end
    end

    initial begin
        logic [8:0] data;
        logic [8:0] mask;
        logic       pbit;
        logic [1:0] stops;
        int         wait_cnt;

        for (int k = 0; k < 3; k++) last[k] = '{9'd0, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        rx    = 3'b111;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_hold(k);
            check("reset_debug_state", k, 32'(ds[k]), 32'(uart_pkg::ST_IDLE));
        end
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        send_frame(1, 9'h007, 1'b0, 2'b11);
        send_frame(2, 9'h055, 1'b1, 2'b01);
        for (int k = 0; k < 3; k++) check_hold(k);

        // Line held low for 20 bit times: one break frame, then parked until high.
        exp_q[0].push_back(model(0, 9'h000, 1'b0, 2'b00));
        rx[0] = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        check("break_wait_state", 0, 32'(ds[0]), 32'(uart_pkg::ST_BREAK_WAIT));
        repeat (5 * CPB) @(negedge clk);
        check("break_wait_held", 0, 32'(ds[0]), 32'(uart_pkg::ST_BREAK_WAIT));
        rx[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break_exit_idle", 0, 32'(ds[0]), 32'(uart_pkg::ST_IDLE));
        check_hold(0);

        // Short low glitch must be rejected at the start-bit midpoint.
        rx[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_idle", 0, 32'(ds[0]), 32'(uart_pkg::ST_IDLE));
        check_hold(0);

        // Reset in the middle of data bit 4 of 0x3C, then a clean 0x81.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, data_bit(9'h03C, i));
        rx[0] = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) last[k] = '{9'd0, 1'b0, 1'b0, 1'b0};
        check_hold(0);
        check("midreset_state", 0, 32'(ds[0]), 32'(uart_pkg::ST_IDLE));
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_hold(0);
        send_frame(0, 9'h081, 1'b0, 2'b11);
        check_hold(0);

        // Randomised frames with occasional parity and stop-bit corruption.
        for (int k = 0; k < 3; k++) begin
            mask = (cfg_bits(k) == 7) ? 9'h07F : 9'h0FF;
            for (int n = 0; n < 10; n++) begin
                data = 9'($urandom) & mask;
                pbit = 1'b0;
                if (cfg_pmode(k) == 1) pbit = ~(^data);
                if (cfg_pmode(k) == 2) pbit = ^data;
                if (cfg_pmode(k) != 0 && $urandom_range(0, 3) == 0) pbit = ~pbit;
                stops[0] = ($urandom_range(0, 4) != 0);
                stops[1] = ($urandom_range(0, 4) != 0);
                send_frame(k, data, pbit, stops);
            end
            check_hold(k);
        end

        wait_cnt = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && wait_cnt < 8 * CPB) begin
            @(negedge clk);
            wait_cnt++;
        end
        for (int k = 0; k < 3; k++) check("pending_frames", k, 32'(exp_q[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic data_bit(input logic [8:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 434, clocks per UART bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0, parity: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Port clock  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port incoming_bit  input  1  asynchronous serial line, idle high.
REQ-008 Port has_data  output  1  one-cycle pulse marking frame completion.
REQ-009 Port data_received  output  DATA_BITS  last completed frame's data, LSB first on the line.
REQ-010 Port parity_error  output  1  parity mismatch in last completed frame.
REQ-011 Port framing_error  output  1  a stop bit sampled low in last completed frame.
REQ-012 Port break_detected  output  1  last completed frame was a line break.
REQ-013 Port debug_state  output  3  registered copy of current FSM state, one cycle delayed.

Function
REQ-014 incoming_bit SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, CLEANUP, BREAK_WAIT.
REQ-016 IDLE SHALL move to START_BIT on synchronized line low; bit counter and index cleared.
REQ-017 START_BIT SHALL sample at count (CLOCKS_PER_BIT-1)/2; low -> DATA_BITS with counter cleared; high -> IDLE with no has_data and no flag change.
REQ-018 DATA_BITS SHALL sample one bit every CLOCKS_PER_BIT clocks into an internal shift register, index 0 first, for DATA_BITS samples.
REQ-019 After the last data bit the FSM SHALL enter PARITY_BIT if PARITY_MODE != 0, else STOP_BIT.
REQ-020 PARITY_BIT SHALL sample once after CLOCKS_PER_BIT clocks; error when XOR(data, parity bit) is 0 for odd or 1 for even.
REQ-021 STOP_BIT SHALL sample STOP_BITS bits at CLOCKS_PER_BIT spacing; any low sample sets framing error.
REQ-022 On the final stop sample the FSM SHALL enter CLEANUP; in that same edge data_received, parity_error, framing_error and break_detected SHALL update and has_data SHALL go high.
REQ-023 has_data SHALL be high for exactly one clock; every completed frame pulses it, errored or not.
REQ-024 Flags and data_received SHALL hold until the next completed frame.
REQ-025 Break: all data bits 0, parity bit 0 if enabled, and all stop bits 0 -> break_detected=1, framing_error=1, parity_error=0.
REQ-026 CLEANUP SHALL go to BREAK_WAIT if break, else IDLE; BREAK_WAIT SHALL stay until the synchronized line is high, then go to IDLE.
REQ-027 Bit counter width SHALL be $clog2(CLOCKS_PER_BIT); no overflow for any legal value.
REQ-028 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, counters 0, synchronizer flops 1, has_data 0, data_received 0, all flags 0, debug_state IDLE.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-031 Package uart_pkg SHALL hold state encodings and PARITY_NONE/ODD/EVEN constants.
REQ-032 Sub-module uart_bit_timer SHALL hold the per-bit counter with half-bit and full-bit ticks.

Verification (CLOCKS_PER_BIT=16)
REQ-033 8N1, send 0xA5 -> one has_data pulse, data_received=0xA5, all flags 0.
REQ-034 8E1, send 0x07 with parity bit 0 -> data_received=0x07, parity_error=1, framing_error=0.
REQ-035 7O2, send 0x55 with second stop bit low -> has_data pulse, data_received=0x55, framing_error=1.
REQ-036 8N1, hold line low 20 bit times -> break_detected=1, framing_error=1, has_data once, FSM in BREAK_WAIT until line high.
REQ-037 Low glitch of 5 clocks -> return to IDLE, no has_data, outputs unchanged.
REQ-038 reset_n low at data bit 4 of 0x3C, then clean 0x81 -> only 0x81 reported, one has_data pulse.
